// File: rtl/fb_scanout.sv
// fb_scanout: maps raster coordinates onto a 1-bpp framebuffer, fetches pixel words
// from a read port and emits colour with syncs delayed to match the fetch pipeline.
module fb_scanout #(
    parameter int unsigned SCREEN_BASE = 16384,
    parameter int unsigned FB_WIDTH    = 512,
    parameter int unsigned FB_HEIGHT   = 256,
    parameter int unsigned WORD_BITS   = 16,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned X_OFF       = 0,
    parameter int unsigned Y_OFF       = 0,
    parameter int unsigned RAM_LAT     = 1,
    parameter int unsigned COLOR_W     = 4,
    parameter logic [3*COLOR_W-1:0] FG     = 12'hFFF,
    parameter logic [3*COLOR_W-1:0] BG     = 12'h000,
    parameter logic [3*COLOR_W-1:0] BORDER = 12'h000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [COORD_W-1:0]   i_px,
    input  logic [COORD_W-1:0]   i_py,
    input  logic                 i_de,
    input  logic                 i_hs,
    input  logic                 i_vs,
    input  logic                 i_invert,
    output logic [ADDR_W-1:0]    o_addr,
    input  logic [WORD_BITS-1:0] i_data,
    output logic [COLOR_W-1:0]   o_r,
    output logic [COLOR_W-1:0]   o_g,
    output logic [COLOR_W-1:0]   o_b,
    output logic                 o_hs,
    output logic                 o_vs,
    output logic                 o_in_win
);

    localparam int unsigned WORDS_PER_ROW = FB_WIDTH / WORD_BITS;
    localparam int unsigned BIT_W         = $clog2(WORD_BITS);
    localparam int unsigned STAGES        = RAM_LAT + 1;
    localparam int unsigned RGB_W         = 3 * COLOR_W;

    // Per-pixel attributes that must travel alongside the RAM read.
    typedef struct packed {
        logic [BIT_W-1:0] bit_idx;
        logic             win;
        logic             de;
        logic             inv;
        logic             hs;
        logic             vs;
    } tap_t;

    logic [COORD_W-1:0] fx, fy;
    logic               x_ok, y_ok, win;
    logic [ADDR_W-1:0]  addr_d, addr_q;
    tap_t               tap_d, tap;
    tap_t               tap_q [STAGES];
    logic [RGB_W-1:0]   rgb_d, rgb_q;
    logic               hs_q, vs_q, in_win_q;

    // Stage 0: window test; the >= guards keep the unsigned subtraction from wrapping in.
    always_comb begin
        x_ok = i_px >= COORD_W'(X_OFF);
        y_ok = i_py >= COORD_W'(Y_OFF);
        fx   = (i_px - COORD_W'(X_OFF)) >> SCALE_SHIFT;
        fy   = (i_py - COORD_W'(Y_OFF)) >> SCALE_SHIFT;
        win  = i_de && x_ok && y_ok && (32'(fx) < FB_WIDTH) && (32'(fy) < FB_HEIGHT);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        addr_d = ADDR_W'(SCREEN_BASE);
        if (win) begin
            addr_d = ADDR_W'(SCREEN_BASE + 32'(fy) * WORDS_PER_ROW + 32'(fx >> BIT_W));
        end
    end

    always_comb begin
        tap_d         = '0;
        tap_d.bit_idx = fx[BIT_W-1:0];
        tap_d.win     = win;
        tap_d.de      = i_de;
        tap_d.inv     = i_invert;
        tap_d.hs      = i_hs;
        tap_d.vs      = i_vs;
    end

    assign tap = tap_q[STAGES-1];

    // Bit 0 of a word is the leftmost pixel; invert only touches window pixels.
    always_comb begin
        rgb_d = '0;
        if (tap.de) begin
            if (tap.win) begin
                rgb_d = (i_data[tap.bit_idx] ^ tap.inv) ? FG : BG;
            end else begin
                rgb_d = BORDER;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // previous stage's old value. The delay line is cleared on reset as well, so the
    // first L-1 outputs after release read as blanking instead of stale pixels.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q <= ADDR_W'(SCREEN_BASE);
            for (int i = 0; i < int'(STAGES); i++) begin
                tap_q[i] <= '0;
            end
            rgb_q    <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            in_win_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            tap_q[0] <= tap_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                tap_q[i] <= tap_q[i-1];
            end
            rgb_q    <= rgb_d;
            hs_q     <= tap.hs;
            vs_q     <= tap.vs;
            in_win_q <= tap.win;
        end
    end

    assign o_addr   = addr_q;
    assign o_r      = rgb_q[RGB_W-1 -: COLOR_W];
    assign o_g      = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign o_b      = rgb_q[COLOR_W-1:0];
    assign o_hs     = hs_q;
    assign o_vs     = vs_q;
    assign o_in_win = in_win_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: three instances (default map, offset window, 2x scale) with
// RAM latencies 1/2/3, directed vectors plus a per-cycle reference check.
module tb_fb_scanout;

    typedef struct {
        logic [14:0] addr;
        logic        win;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] px, py;
    logic        de, hs, vs, invert;

    logic [15:0] mem [32768];

    logic [14:0] def_addr, win_addr, scl_addr;
    logic [15:0] def_data, win_data, scl_data;
    logic [15:0] win_rd [2];
    logic [15:0] scl_rd [3];
    logic [3:0]  def_r, def_g, def_b, win_r, win_g, win_b, scl_r, scl_g, scl_b;
    logic        def_hs, def_vs, def_win, win_hs, win_vs, win_win, scl_hs, scl_vs, scl_win;
    logic [14:0] def_pix, win_pix, scl_pix;

    int n_vec = 0;
    int n_bad = 0;
    int n_edge = 0;
    int h_px [16];
    int h_py [16];
    bit h_de [16];
    bit h_inv [16];
    bit h_hs [16];
    bit h_vs [16];
    bit h_rst [16];
    int py_list [6] = '{2, 255, 256, 257, 511, 512};

    always #5 clk = ~clk;

    fb_scanout u_def (
        .i_clk(clk), .i_rst(rst), .i_px(px), .i_py(py), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_invert(invert), .o_addr(def_addr), .i_data(def_data),
        .o_r(def_r), .o_g(def_g), .o_b(def_b), .o_hs(def_hs), .o_vs(def_vs), .o_in_win(def_win)
    );

    fb_scanout #(.X_OFF(256), .Y_OFF(256), .RAM_LAT(2), .BORDER(12'h0A5)) u_win (
        .i_clk(clk), .i_rst(rst), .i_px(px), .i_py(py), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_invert(invert), .o_addr(win_addr), .i_data(win_data),
        .o_r(win_r), .o_g(win_g), .o_b(win_b), .o_hs(win_hs), .o_vs(win_vs), .o_in_win(win_win)
    );

    fb_scanout #(.SCALE_SHIFT(1), .RAM_LAT(3), .BORDER(12'h5A0)) u_scl (
        .i_clk(clk), .i_rst(rst), .i_px(px), .i_py(py), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_invert(invert), .o_addr(scl_addr), .i_data(scl_data),
        .o_r(scl_r), .o_g(scl_g), .o_b(scl_b), .o_hs(scl_hs), .o_vs(scl_vs), .o_in_win(scl_win)
    );

    assign def_pix = {def_win, def_hs, def_vs, def_r, def_g, def_b};
    assign win_pix = {win_win, win_hs, win_vs, win_r, win_g, win_b};
    assign scl_pix = {scl_win, scl_hs, scl_vs, scl_r, scl_g, scl_b};

    // RAM read ports with 1, 2 and 3 cycles of latency.
    always @(posedge clk) def_data <= mem[def_addr];
    always @(posedge clk) begin
        win_rd[0] <= mem[win_addr];
        win_rd[1] <= win_rd[0];
    end
    always @(posedge clk) begin
        scl_rd[0] <= mem[scl_addr];
        scl_rd[1] <= scl_rd[0];
        scl_rd[2] <= scl_rd[1];
    end
    assign win_data = win_rd[1];
    assign scl_data = scl_rd[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input bit d, input bit iv,
                                   input int xo, input int yo, input int s,
                                   input logic [11:0] border);
        exp_t        e;
        int          fx, fy;
        logic [15:0] w;
        fx     = (x - xo) >>> s;
        fy     = (y - yo) >>> s;
        e.win  = d && (x >= xo) && (y >= yo) && (fx < 512) && (fy < 256);
        e.addr = e.win ? 15'(16384 + fy * 32 + fx / 16) : 15'd16384;
        w      = mem[e.addr];
        if (!d)          e.rgb = 12'h000;
        else if (!e.win) e.rgb = border;
        else             e.rgb = (w[fx % 16] ^ iv) ? 12'hFFF : 12'h000;
        return e;
    endfunction

    // Output after edge n reflects the inputs of cycle n-L unless a reset edge
    // occurred in between; o_addr reflects cycle n-1.
    task automatic mon_chk(input string tag, input int lat, input int xo, input int yo,
                           input int s, input logic [11:0] border,
                           input logic [14:0] got_addr, input logic [14:0] got_pix);
        int          lat_tot, k;
        bit          any_rst;
        exp_t        e;
        logic [14:0] exp_pix;
        lat_tot = lat + 2;
        k = (n_edge - 1) % 16;
        e = model(h_px[k], h_py[k], h_de[k], h_inv[k], xo, yo, s, border);
        chk({tag, "_addr"}, 32'(got_addr), 32'(h_rst[k] ? 15'd16384 : e.addr));
        any_rst = 1'b0;
        for (int j = 1; j <= lat_tot; j++) any_rst |= h_rst[(n_edge - j) % 16];
        k = (n_edge - lat_tot) % 16;
        e = model(h_px[k], h_py[k], h_de[k], h_inv[k], xo, yo, s, border);
        exp_pix = any_rst ? 15'd0 : {e.win, h_hs[k], h_vs[k], e.rgb};
        chk({tag, "_pix"}, 32'(got_pix), 32'(exp_pix));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            h_px[n_edge % 16]  = int'(px);
            h_py[n_edge % 16]  = int'(py);
            h_de[n_edge % 16]  = de;
            h_inv[n_edge % 16] = invert;
            h_hs[n_edge % 16]  = hs;
            h_vs[n_edge % 16]  = vs;
            h_rst[n_edge % 16] = rst;
            n_edge++;
            #1;
            if (n_edge > 6) begin
                mon_chk("def", 1, 0, 0, 0, 12'h000, def_addr, def_pix);
                mon_chk("win", 2, 256, 256, 0, 12'h0A5, win_addr, win_pix);
                mon_chk("scl", 3, 0, 0, 1, 12'h5A0, scl_addr, scl_pix);
            end
        end
    end

    task automatic step(input int x, input int y, input bit d, input bit iv,
                        input bit h, input bit v, input bit r);
        px = 11'(x);
        py = 11'(y);
        de = d;
        invert = iv;
        hs = h;
        vs = v;
        rst = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = (a % 2 == 1) ? 16'hA5A5 : 16'h0F0F;
        mem[16449] = 16'h0002;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(0, 2047), $urandom_range(0, 2047), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        chk("rst_addr", 32'(def_addr), 32'd16384);
        chk("rst_def_pix", 32'(def_pix), 32'd0);
        chk("rst_scl_pix", 32'(scl_pix), 32'd0);

        // Default map: px=17, py=2 -> word 16449, bit 1 set
        step(17, 2, 1, 0, 1, 0, 0);
        chk("map_addr", 32'(def_addr), 32'd16449);
        step(17, 2, 1, 0, 1, 0, 0);
        chk("first_out_early", 32'(def_pix), 32'd0);
        step(17, 2, 1, 0, 1, 0, 0);
        chk("first_out", 32'(def_pix), 32'({1'b1, 1'b1, 1'b0, 12'hFFF}));
        step(16, 2, 1, 0, 0, 0, 0);
        chk("map_addr16", 32'(def_addr), 32'd16449);
        step(16, 2, 1, 0, 0, 0, 0);
        step(16, 2, 1, 0, 0, 0, 0);
        chk("map_bit0", 32'(def_pix), 32'({1'b1, 1'b0, 1'b0, 12'h000}));

        // Offset window
        step(255, 256, 1, 0, 0, 0, 0);
        chk("win_left_addr", 32'(win_addr), 32'd16384);
        for (int i = 0; i < 3; i++) step(255, 256, 1, 0, 0, 0, 0);
        chk("win_left_border", 32'(win_pix), 32'({1'b0, 1'b0, 1'b0, 12'h0A5}));
        step(256, 256, 1, 0, 0, 0, 0);
        chk("win_origin_addr", 32'(win_addr), 32'd16384);
        for (int i = 0; i < 3; i++) step(256, 256, 1, 0, 0, 0, 0);
        chk("win_origin_pix", 32'(win_pix), 32'({1'b1, 1'b0, 1'b0, 12'hFFF}));
        step(767, 256, 1, 0, 0, 0, 0);
        chk("win_right_addr", 32'(win_addr), 32'd16415);
        for (int i = 0; i < 3; i++) step(767, 256, 1, 0, 0, 0, 0);
        chk("win_right_pix", 32'(win_pix), 32'({1'b1, 1'b0, 1'b0, 12'hFFF}));
        for (int i = 0; i < 4; i++) step(768, 256, 1, 0, 0, 0, 0);
        chk("win_right_border", 32'(win_pix), 32'({1'b0, 1'b0, 1'b0, 12'h0A5}));

        // 2x scale: 32 display pixels per word
        for (int x = 0; x < 64; x++) begin
            step(x, 0, 1, 0, 0, 0, 0);
            chk("scl_map", 32'(scl_addr), (x < 32) ? 32'd16384 : 32'd16385);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Last framebuffer pixel, then border, then de falling edge
        step(511, 255, 1, 0, 0, 0, 0);
        chk("last_addr", 32'(def_addr), 32'd24575);
        step(512, 255, 1, 0, 0, 0, 0);
        chk("past_last_addr", 32'(def_addr), 32'd16384);
        step(513, 255, 0, 0, 0, 0, 0);
        chk("last_pix", 32'(def_pix), 32'({1'b1, 1'b0, 1'b0, 12'hFFF}));
        step(514, 255, 0, 0, 0, 0, 0);
        chk("past_last_pix", 32'(def_pix), 32'd0);
        step(515, 255, 0, 0, 0, 0, 0);
        chk("blank_pix", 32'(def_pix), 32'd0);

        // Mini raster, two frames, invert on in the second frame
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 6; l++) begin
                for (int h = 0; h < 64; h++) begin
                    step(240 + h, py_list[l], h < 48, (f == 1) && (h >= 20),
                         (h >= 52) && (h < 58), l == 0, 0);
                end
            end
        end

        // Invert from px=100, reset pulse at px=300
        for (int x = 90; x < 320; x++) begin
            step(x, 3, 1, x >= 100, 0, 0, (x == 300) || (x == 301));
            if (x == 301) begin
                chk("midrst_addr", 32'(def_addr), 32'd16384);
                chk("midrst_pix", 32'(def_pix), 32'd0);
            end
        end
        for (int i = 0; i < 8; i++) step(0, 4, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
